// File: rtl/blockarray_ctrl_if.sv
// Bus bundle between the stacker game logic / pixel path and the block-array controller.
// The master drives requests and the read row; the slave owns the array and reports status.
interface blockarray_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3
);
  logic            tick;
  logic            clr_req;
  logic            wipe_req;
  logic            wr_req;
  logic [RW-1:0]   wr_row;
  logic [COLS-1:0] wr_data;
  logic            wr_ack;
  logic [RW-1:0]   rd_row;
  logic [COLS-1:0] rd_data;
  logic [ROWS-1:0] occ;
  logic [RW:0]     height;
  logic            busy;
  logic            done;

  modport master (
    output tick, clr_req, wipe_req, wr_req, wr_row, wr_data, rd_row,
    input  wr_ack, rd_data, occ, height, busy, done
  );

  modport slave (
    input  tick, clr_req, wipe_req, wr_req, wr_row, wr_data, rd_row,
    output wr_ack, rd_data, occ, height, busy, done
  );
endinterface

// File: rtl/blockarray_ctrl.sv
// Block-array register file for the VGA stacker: single-row writes, fast clear,
// tick-paced top-down wipe, a 1-cycle read port and registered occupancy/height.
module blockarray_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = 3
) (
  input  logic                clk,
  input  logic                reset,
  blockarray_ctrl_if.slave    bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] WIPE  = 2'd2;

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [RW:0]   ROW_LIMIT = (RW + 1)'(ROWS);

  logic [1:0]      state_q, state_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic [COLS-1:0] row_q [ROWS];

  logic            row_we;
  logic [RW-1:0]   row_idx;
  logic [COLS-1:0] row_wdata;
  logic            write_ok;
  logic            wr_in_range;
  logic            rd_in_range;

  logic [COLS-1:0] rd_q;
  logic [ROWS-1:0] occ_q, occ_d;
  logic [RW:0]     height_q, height_d;

  assign wr_in_range = ({1'b0, bus.wr_row} < ROW_LIMIT);
  assign rd_in_range = ({1'b0, bus.rd_row} < ROW_LIMIT);

  // A restart or game-over request in the same cycle wins over the write.
  assign write_ok = (state_q == IDLE) && bus.wr_req && !bus.clr_req && !bus.wipe_req;

  // Next-state and sweep pointer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (bus.wipe_req) begin
          state_d = WIPE;
          ptr_d   = LAST_ROW;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_ROW) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + RW'(1);
        end
      end
      WIPE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (bus.tick) begin
          if (ptr_q == '0) begin
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q - RW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Single write port into the array, shared by all three update sources.
  always_comb begin
    row_we    = 1'b0;
    row_idx   = bus.wr_row;
    row_wdata = bus.wr_data;
    case (state_q)
      IDLE: row_we = write_ok && wr_in_range;
      CLEAR: begin
        row_we    = 1'b1;
        row_idx   = ptr_q;
        row_wdata = '0;
      end
      WIPE: begin
        // An aborting clear skips this row; CLEAR wipes it anyway.
        row_we    = bus.tick && !bus.clr_req;
        row_idx   = ptr_q;
        row_wdata = '0;
      end
      default: row_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the array is a flop-based register file whose contents must read as
    // empty right after reset, so every row is reset explicitly.
    if (reset) begin
      for (int i = 0; i < ROWS; i++) row_q[i] <= '0;
    end else if (row_we) begin
      row_q[row_idx] <= row_wdata;
    end
  end

  // Occupancy and stack height from the current array contents.
  always_comb begin
    occ_d    = '0;
    height_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      occ_d[i] = |row_q[i];
      if (|row_q[i]) height_d = (RW + 1)'(i + 1);
    end
  end

  // Read port returns pre-write data when a write lands on the same row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= '0;
      occ_q    <= '0;
      height_q <= '0;
    end else begin
      rd_q     <= rd_in_range ? row_q[bus.rd_row] : '0;
      occ_q    <= occ_d;
      height_q <= height_d;
    end
  end

  assign bus.rd_data = rd_q;
  assign bus.occ     = occ_q;
  assign bus.height  = height_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.wr_ack  = write_ok && !reset;
  assign bus.done    = ((state_q == CLEAR) && (ptr_q == LAST_ROW)) ||
                       ((state_q == WIPE) && bus.tick && !bus.clr_req && (ptr_q == '0));

endmodule
